rcv_protocol: RTL and testbench
===============================

Name: rcv_protocol

Overview:
Serial packet receiver; consumes the single-wire S_Data stream produced by the serial transmit stage in the same clock domain.
- Line idles high. A frame is a start bit 0, then five 1s (preamble), then 55 data bits MSB first.
- The block hunts for the start bit, checks the preamble, and deserialises the payload.
- The payload is presented on RX_Data with a level-valid/ack handshake toward the router core.

Parameters:
DATA_W, 55, payload width in bits
PRE_ONES, 5, number of 1 bits that must follow the start bit
CNT_W, 6, bit counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk  input  1  system clock, shared with the transmitter
rst  input  1  reset, asynchronous, active-high
S_Data  input  1  serial line; idle high; sampled every rising clk edge
rx_ack  input  1  consumer acknowledges the held RX_Data; clears rx_valid
RX_Data  output  DATA_W  last good payload; bit DATA_W-1 is the first data bit received
rx_valid  output  1  level; high while an unacknowledged payload is held
busy  output  1  high in PREAMBLE and DATA states
frame_err  output  1  one-cycle pulse when a preamble bit is sampled as 0
overrun  output  1  sticky; set when a payload completes while rx_valid=1 and rx_ack=0; cleared only by rst

Behaviour:
- Reset values: state=HUNT; RX_Data=0; rx_valid=0; busy=0; frame_err=0; overrun=0; counters=0.
- No input synchroniser. S_Data is treated as synchronous to clk.
- All outputs are registered.
- HUNT:
  - S_Data=0 sampled -> PREAMBLE, pre_cnt=0.
  - S_Data=1 -> stay in HUNT.
- PREAMBLE:
  - Each 1 sampled increments pre_cnt.
  - When the PRE_ONES-th 1 is sampled -> DATA, bit_cnt=DATA_W.
  - A 0 sampled -> frame_err=1 for the next cycle. The 0 is treated as a new start bit: stay in PREAMBLE, pre_cnt=0.
  - A line stuck low therefore pulses frame_err on every cycle after the first.
- DATA:
  - Each edge: shift_reg <= {shift_reg[DATA_W-2:0], S_Data}; bit_cnt decrements.
  - On the edge sampling the last bit (bit_cnt==1): RX_Data <= completed word (including the bit just sampled); rx_valid <= 1; state -> HUNT.
  - Data bits are not checked; 0s in the payload are legal.
- Latency: with the start bit sampled at edge E0, preamble bits are sampled at E1..E5 and data bits at E6..E60.
  - RX_Data and rx_valid update on E60 and are visible in the cycle after E60.
- Back-to-back frames: HUNT is entered directly after the last data bit. The next frame is accepted as soon as the following start bit (0) is sampled; at least one idle 1 is expected between frames.
- Handshake:
  - rx_ack=1 while rx_valid=1 -> rx_valid <= 0 next edge.
  - rx_ack while rx_valid=0 is ignored.
- Completion while rx_valid=1:
  - With rx_ack=0 in the same cycle: RX_Data is overwritten with the new word, rx_valid stays 1, overrun <= 1.
  - With rx_ack=1 in the same cycle: RX_Data loads the new word, rx_valid stays 1, no overrun.
- rst mid-frame: frame abandoned and all state cleared; the partial word is never presented.
- busy=1 exactly when state is PREAMBLE or DATA; updated together with state.

Decomposition:
- Shared package/include holds:
  - State encodings: HUNT=2'd0, PREAMBLE=2'd1, DATA=2'd2.
  - DATA_W=55 and PRE_ONES=5.
  - Frame header constant 6'b01_1111, shared with the transmit stage.
- One natural sub-module: rcv_shift_reg (DATA_W serial-in/parallel-out shifter with a load-enable output register).
- FSM and handshake stay in the top module.

Test Plan:
- Drive one frame with payload 55'h12_3456_789A_BCDE (start bit at E0, data at E6..E60) -> RX_Data=55'h12_3456_789A_BCDE, rx_valid rises in the cycle after E60, frame_err=0, busy high from E1 through E60.
- Drive 0,1,1,0,1,1,1,1,1 then a 55-bit payload of 55'h7F_FFFF_FFFF_FFFF -> exactly one frame_err pulse (from the 0 at the 4th sample); frame accepted from the second 0 as start bit; RX_Data=55'h7F_FFFF_FFFF_FFFF.
- Send two frames, payloads 55'h1 then 55'h2, no rx_ack -> RX_Data=55'h2, rx_valid=1, overrun=1. Repeat with rx_ack held high on the completion edge of the second frame -> overrun=0, rx_valid=1.
- Assert rst at data bit 30 of a frame, then send a clean frame with payload 55'h55_5555_5555_5555 -> no rx_valid before the clean frame; RX_Data=55'h55_5555_5555_5555 after it.
- Hold S_Data=1 for 200 cycles after reset -> busy=0, rx_valid=0, frame_err=0 throughout. Then hold S_Data=0 for 10 cycles -> 9 frame_err pulses.
- Connect the transmitter stage back-to-back with random 55-bit payloads, pulsing rx_ack after each rx_valid -> 100 frames received in order, no frame_err, no overrun.

Source files
------------

// File: rtl/rcv_protocol_pkg.sv
// Shared definitions for the serial packet receiver and its transmit partner.
// Holds the state encoding, frame geometry and the frame header constant.
package rcv_protocol_pkg;

  localparam int unsigned DATA_W   = 55;
  localparam int unsigned PRE_ONES = 5;
  localparam int unsigned CNT_W    = 6;

  // Start bit followed by the preamble ones, as sent on the wire.
  localparam logic [5:0] FRAME_HDR = 6'b01_1111;

  typedef enum logic [1:0] {
    StHunt     = 2'd0,
    StPreamble = 2'd1,
    StData     = 2'd2
  } rcv_state_e;

endpackage

// File: rtl/rcv_shift_reg.sv
// Serial-in/parallel-out shifter with a load-enabled output word register.
// The output register captures the word including the bit shifted in this cycle.
module rcv_shift_reg #(
  parameter int unsigned DATA_W = 55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              s_in,
  input  logic              load_en,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] next_word;

  assign next_word = {shift_q[DATA_W-2:0], s_in};
  assign data_out  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      if (shift_en) shift_q <= next_word;
      if (load_en)  data_q  <= next_word;
    end
  end

endmodule

// File: rtl/rcv_protocol.sv
// Serial packet receiver: hunts for a start bit, checks the preamble and
// deserialises the payload, presenting it with a level valid/ack handshake.
module rcv_protocol
  import rcv_protocol_pkg::*;
#(
  parameter int unsigned DATA_W   = rcv_protocol_pkg::DATA_W,
  parameter int unsigned PRE_ONES = rcv_protocol_pkg::PRE_ONES,
  parameter int unsigned CNT_W    = rcv_protocol_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_Data,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] RX_Data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  rcv_state_e        state_q, state_d;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              shift_en;
  logic              load_en;

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    frame_err_d = 1'b0;
    shift_en    = 1'b0;
    load_en     = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (!S_Data) begin
          state_d   = StPreamble;
          pre_cnt_d = '0;
        end
      end
      StPreamble: begin
        if (S_Data) begin
          if (pre_cnt_q == CNT_W'(PRE_ONES - 1)) begin
            state_d   = StData;
            bit_cnt_d = CNT_W'(DATA_W);
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end else begin
          // A broken preamble zero doubles as a fresh start bit.
          frame_err_d = 1'b1;
          pre_cnt_d   = '0;
        end
      end
      StData: begin
        shift_en  = 1'b1;
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == CNT_W'(1)) begin
          load_en = 1'b1;
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase

    busy_d = (state_d != StHunt);

    rx_valid_d = rx_valid_q;
    if (load_en) begin
      rx_valid_d = 1'b1;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    overrun_d = overrun_q | (load_en & rx_valid_q & ~rx_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  rcv_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .s_in     (S_Data),
    .load_en  (load_en),
    .data_out (RX_Data)
  );

  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rcv_protocol.sv
// Directed bench for rcv_protocol: single frames, preamble errors, overrun,
// mid-frame reset, idle/stuck line and a 100-frame looped-back stream.
module tb_rcv_protocol;
  import rcv_protocol_pkg::*;

  logic              clk;
  logic              rst;
  logic              S_Data;
  logic              rx_ack;
  logic [DATA_W-1:0] RX_Data;
  logic              rx_valid;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  int n_checks;
  int n_fails;
  int fe_cnt;
  int valid_cnt;
  int busy_bad;
  int busy_cyc;
  int valid_at_59;
  bit auto_ack;
  bit ack_hold;
  logic [DATA_W-1:0] exp_q[$];

  rcv_protocol u_dut (
    .clk       (clk),
    .rst       (rst),
    .S_Data    (S_Data),
    .rx_ack    (rx_ack),
    .RX_Data   (RX_Data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs, clock, then observe #1 after the edge.
  task automatic drive_bit(input logic b);
    logic [DATA_W-1:0] exp;
    S_Data = b;
    rx_ack = ack_hold;
    if (auto_ack && rx_valid) begin
      rx_ack = 1'b1;
      if (exp_q.size() == 0) begin
        check_eq("stream_unexpected_word", 64'(RX_Data), 64'h0);
      end else begin
        exp = exp_q.pop_front();
        check_eq("stream_word", 64'(RX_Data), 64'(exp));
      end
    end
    @(posedge clk);
    #1;
    if (frame_err) fe_cnt++;
    if (rx_valid)  valid_cnt++;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] payload);
    logic [60:0] frame;
    frame = {FRAME_HDR, payload};
    for (int i = 0; i < 61; i++) begin
      drive_bit(frame[60-i]);
      if (busy !== (i < 60)) busy_bad++;
      if (busy) busy_cyc++;
      if (i == 59) valid_at_59 = int'(rx_valid);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    S_Data = 1'b1;
    idle(1);
  endtask

  task automatic ack_now();
    ack_hold = 1'b1;
    idle(1);
    ack_hold = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] p;
    logic [8:0]        pre;
    n_checks = 0; n_fails = 0; fe_cnt = 0; valid_cnt = 0;
    busy_bad = 0; busy_cyc = 0; valid_at_59 = 0;
    auto_ack = 1'b0; ack_hold = 1'b0;
    rst = 1'b1; S_Data = 1'b1; rx_ack = 1'b0;
    #12;
    check_eq("reset_rx_data", 64'(RX_Data), 64'h0);
    check_eq("reset_rx_valid", 64'(rx_valid), 64'h0);
    check_eq("reset_busy", 64'(busy), 64'h0);
    check_eq("reset_frame_err", 64'(frame_err), 64'h0);
    check_eq("reset_overrun", 64'(overrun), 64'h0);
    rst = 1'b0;
    idle(2);

    // Single clean frame
    fe_cnt = 0;
    send_frame(55'h12_3456_789A_BCDE);
    check_eq("t1_rx_data", 64'(RX_Data), 64'h12_3456_789A_BCDE);
    check_eq("t1_valid_after_e60", 64'(rx_valid), 64'h1);
    check_eq("t1_valid_before_e60", 64'(valid_at_59), 64'h0);
    check_eq("t1_busy_profile", 64'(busy_bad), 64'h0);
    check_eq("t1_busy_cycles", 64'(busy_cyc), 64'd60);
    check_eq("t1_frame_err", 64'(fe_cnt), 64'h0);
    ack_now();
    check_eq("t1_ack_clears", 64'(rx_valid), 64'h0);
    idle(1);
    check_eq("t1_ack_idle_ignored", 64'(rx_valid), 64'h0);

    // Broken preamble, restart from the second zero
    fe_cnt = 0;
    pre = 9'b0_1101_1111;
    for (int i = 8; i >= 0; i--) drive_bit(pre[i]);
    p = 55'h7F_FFFF_FFFF_FFFF;
    for (int i = DATA_W - 1; i >= 0; i--) drive_bit(p[i]);
    check_eq("t2_frame_err_pulses", 64'(fe_cnt), 64'd1);
    check_eq("t2_rx_data", 64'(RX_Data), 64'h7F_FFFF_FFFF_FFFF);
    check_eq("t2_rx_valid", 64'(rx_valid), 64'h1);
    ack_now();

    // Two frames without ack -> overrun
    send_frame(55'h1);
    idle(1);
    send_frame(55'h2);
    check_eq("t3_rx_data", 64'(RX_Data), 64'h2);
    check_eq("t3_rx_valid", 64'(rx_valid), 64'h1);
    check_eq("t3_overrun", 64'(overrun), 64'h1);
    idle(3);
    ack_now();
    check_eq("t3_overrun_sticky", 64'(overrun), 64'h1);
    do_reset();
    check_eq("t3_overrun_rst", 64'(overrun), 64'h0);

    // Same, but ack coincides with the second completion
    send_frame(55'h1);
    idle(1);
    p = 55'h2;
    for (int i = 0; i < 6; i++) drive_bit(FRAME_HDR[5-i]);
    for (int i = DATA_W - 1; i >= 1; i--) drive_bit(p[i]);
    ack_hold = 1'b1;
    drive_bit(p[0]);
    ack_hold = 1'b0;
    check_eq("t3b_overrun", 64'(overrun), 64'h0);
    check_eq("t3b_rx_valid", 64'(rx_valid), 64'h1);
    check_eq("t3b_rx_data", 64'(RX_Data), 64'h2);
    ack_now();

    // Reset at data bit 30, then a clean frame
    valid_cnt = 0;
    p = 55'h3F_0F0F_0F0F_0F0F;
    for (int i = 0; i < 6; i++) drive_bit(FRAME_HDR[5-i]);
    for (int i = DATA_W - 1; i > DATA_W - 31; i--) drive_bit(p[i]);
    do_reset();
    check_eq("t4_busy_after_rst", 64'(busy), 64'h0);
    check_eq("t4_data_after_rst", 64'(RX_Data), 64'h0);
    send_frame(55'h55_5555_5555_5555);
    check_eq("t4_valid_count", 64'(valid_cnt), 64'd1);
    check_eq("t4_rx_data", 64'(RX_Data), 64'h55_5555_5555_5555);
    ack_now();

    // Idle line, then stuck low
    do_reset();
    fe_cnt = 0; valid_cnt = 0; busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      drive_bit(1'b1);
      if (busy) busy_cyc++;
    end
    check_eq("t5_idle_busy", 64'(busy_cyc), 64'h0);
    check_eq("t5_idle_valid", 64'(valid_cnt), 64'h0);
    check_eq("t5_idle_frame_err", 64'(fe_cnt), 64'h0);
    for (int i = 0; i < 10; i++) drive_bit(1'b0);
    check_eq("t5_stuck_low_pulses", 64'(fe_cnt), 64'd9);
    do_reset();

    // Looped-back stream of random payloads with auto ack
    fe_cnt = 0;
    auto_ack = 1'b1;
    for (int f = 0; f < 100; f++) begin
      p = {23'($urandom), 32'($urandom)};
      exp_q.push_back(p);
      send_frame(p);
      idle(1);
    end
    idle(4);
    auto_ack = 1'b0;
    check_eq("t6_all_received", 64'(exp_q.size()), 64'h0);
    check_eq("t6_frame_err", 64'(fe_cnt), 64'h0);
    check_eq("t6_overrun", 64'(overrun), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
